// File: rtl/pipeline_hazard_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// pipeline_hazard_ctrl_pkg
// Shared types and defaults for the pipeline sequencing controller.
//   ctrl_state_t        : controller state (IDLE, RUN, DRAIN, HALTED)
//   REG_ADDR_W_DEF      : register-file address width
//   DRAIN_CYCLES_DEF    : bubble cycles needed to retire in-flight work on halt
// -----------------------------------------------------------------------------
package pipeline_hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_HALTED = 2'd3
    } ctrl_state_t;

    localparam int REG_ADDR_W_DEF   = 5;
    localparam int DRAIN_CYCLES_DEF = 4;

endpackage

// File: rtl/pipeline_hazard_ctrl_sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
// Saturating up-counter used for the pipeline performance counters.
//   clk   : system clock
//   rst   : synchronous active-high clear
//   inc   : count one event this cycle
//   count : current value, sticks at all-ones instead of wrapping
// -----------------------------------------------------------------------------
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            count_reg <= '0;
        end else if (inc && (count_reg != {WIDTH{1'b1}})) begin
            count_reg <= count_reg + WIDTH'(1);
        end
    end

    assign count = count_reg;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipeline_hazard_ctrl
// Central sequencing controller for the 5-stage pipeline. Produces the PC
// enable and every pipeline-register enable/flush from load-use, redirect and
// data-memory-wait conditions, and runs the IDLE/RUN/DRAIN/HALTED sequence.
//
// Inputs : clk, rst (sync, active high), enable (start, level), halt_req,
//          id_rs/id_rt/id_uses_rs/id_uses_rt (ID operand info),
//          ex_mem_read/ex_rt (load in EX), mem_branch/mem_zero/mem_jump
//          (control transfer resolved in MEM), dmem_wait (memory freeze)
// Outputs: pc_en, if_id_en/flush, id_ex_en/flush, ex_mem_en/flush, mem_wb_en,
//          running, halted, stall_cnt, flush_cnt (saturating)
//
// Enables and flushes are combinational so a hazard acts in the cycle it is
// seen; state, drain counter and perf counters are registered.
// -----------------------------------------------------------------------------
module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int REG_ADDR_W   = REG_ADDR_W_DEF,
    parameter int DRAIN_CYCLES = DRAIN_CYCLES_DEF,
    parameter int CNT_W        = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic                  halt_req,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic                  id_uses_rs,
    input  logic                  id_uses_rt,
    input  logic                  ex_mem_read,
    input  logic [REG_ADDR_W-1:0] ex_rt,
    input  logic                  mem_branch,
    input  logic                  mem_zero,
    input  logic                  mem_jump,
    input  logic                  dmem_wait,
    output logic                  pc_en,
    output logic                  if_id_en,
    output logic                  if_id_flush,
    output logic                  id_ex_en,
    output logic                  id_ex_flush,
    output logic                  ex_mem_en,
    output logic                  ex_mem_flush,
    output logic                  mem_wb_en,
    output logic                  running,
    output logic                  halted,
    output logic [CNT_W-1:0]      stall_cnt,
    output logic [CNT_W-1:0]      flush_cnt
);

    localparam int DRAIN_W = (DRAIN_CYCLES < 1) ? 1 : $clog2(DRAIN_CYCLES + 1);

    ctrl_state_t        state_reg;
    logic [DRAIN_W-1:0] drain_reg;

    logic redirect;
    logic load_use;
    logic active;       // RUN or DRAIN: the pipeline is allowed to move
    logic advance;      // active and not frozen by data memory

    // ---------------------------------------------------------------------
    // Hazard detection. A load targeting $zero never creates a dependency.
    // ---------------------------------------------------------------------
    assign redirect = (mem_branch & mem_zero) | mem_jump;
    assign load_use = ex_mem_read & (ex_rt != '0) &
                      ((id_uses_rs & (id_rs == ex_rt)) |
                       (id_uses_rt & (id_rt == ex_rt)));

    assign active  = (state_reg == ST_RUN) || (state_reg == ST_DRAIN);
    assign advance = active && !dmem_wait;

    // ---------------------------------------------------------------------
    // Enable / flush generation. Priority: memory freeze, redirect, load-use.
    // During DRAIN the front end keeps injecting bubbles into IF/ID and the
    // PC is held, while the downstream stages behave exactly as in RUN.
    // ---------------------------------------------------------------------
    always_comb begin
        pc_en        = 1'b0;
        if_id_en     = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_en     = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_en    = 1'b0;
        ex_mem_flush = 1'b0;
        mem_wb_en    = 1'b0;

        if (advance) begin
            id_ex_en  = 1'b1;
            ex_mem_en = 1'b1;
            mem_wb_en = 1'b1;
            if (redirect) begin
                // Squash everything younger than MEM; load_use is moot.
                pc_en        = 1'b1;
                if_id_en     = 1'b1;
                if_id_flush  = 1'b1;
                id_ex_flush  = 1'b1;
                ex_mem_flush = 1'b1;
            end else if (load_use) begin
                // Hold PC and IF/ID, insert one bubble behind the load.
                id_ex_flush = 1'b1;
            end else begin
                pc_en    = 1'b1;
                if_id_en = 1'b1;
            end

            if (state_reg == ST_DRAIN) begin
                pc_en       = 1'b0;
                if_id_en    = 1'b1;
                if_id_flush = 1'b1;
            end
        end
    end

    assign running = (state_reg == ST_RUN);
    assign halted  = (state_reg == ST_HALTED);

    // ---------------------------------------------------------------------
    // Start / halt sequencer.
    // ---------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            drain_reg <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (enable) begin
                        state_reg <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    // A halt seen while frozen is acted on once memory is ready.
                    if (halt_req && !dmem_wait) begin
                        state_reg <= ST_DRAIN;
                        drain_reg <= DRAIN_W'(DRAIN_CYCLES);
                    end
                end
                ST_DRAIN: begin
                    if (!dmem_wait) begin
                        if (drain_reg <= DRAIN_W'(1)) begin
                            state_reg <= ST_HALTED;
                            drain_reg <= '0;
                        end else begin
                            drain_reg <= drain_reg - DRAIN_W'(1);
                        end
                    end
                end
                ST_HALTED: begin
                    if (!enable) begin
                        state_reg <= ST_IDLE;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    // ---------------------------------------------------------------------
    // Performance counters: [0] load-use stall cycles, [1] redirect events.
    // ---------------------------------------------------------------------
    logic [1:0]       cnt_inc;
    logic [CNT_W-1:0] cnt_val [2];

    assign cnt_inc[0] = advance && !redirect && load_use;
    assign cnt_inc[1] = advance && redirect;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_perf_cnt
            sat_counter #(
                .WIDTH(CNT_W)
            ) u_cnt (
                .clk   (clk),
                .rst   (rst),
                .inc   (cnt_inc[gi]),
                .count (cnt_val[gi])
            );
        end
    endgenerate

    assign stall_cnt = cnt_val[0];
    assign flush_cnt = cnt_val[1];

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipeline_hazard_ctrl
// Directed bench for pipeline_hazard_ctrl. Each cycle the expected control
// vector and counter values are pushed when inputs are driven, then popped and
// compared on the falling edge. A second instance with 2-bit counters shares
// the stimulus to exercise counter saturation.
// -----------------------------------------------------------------------------
module tb_pipeline_hazard_ctrl;
    import pipeline_hazard_ctrl_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic       halt_req;
    logic [4:0] id_rs;
    logic [4:0] id_rt;
    logic       id_uses_rs;
    logic       id_uses_rt;
    logic       ex_mem_read;
    logic [4:0] ex_rt;
    logic       mem_branch;
    logic       mem_zero;
    logic       mem_jump;
    logic       dmem_wait;

    logic        pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush;
    logic        ex_mem_en, ex_mem_flush, mem_wb_en, running, halted;
    logic [15:0] stall_cnt, flush_cnt;

    logic        s_pc_en, s_if_id_en, s_if_id_flush, s_id_ex_en, s_id_ex_flush;
    logic        s_ex_mem_en, s_ex_mem_flush, s_mem_wb_en, s_running, s_halted;
    logic [1:0]  s_stall_cnt, s_flush_cnt;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(
        .REG_ADDR_W(5), .DRAIN_CYCLES(4), .CNT_W(16)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable), .halt_req(halt_req),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .ex_mem_read(ex_mem_read), .ex_rt(ex_rt),
        .mem_branch(mem_branch), .mem_zero(mem_zero), .mem_jump(mem_jump),
        .dmem_wait(dmem_wait),
        .pc_en(pc_en), .if_id_en(if_id_en), .if_id_flush(if_id_flush),
        .id_ex_en(id_ex_en), .id_ex_flush(id_ex_flush),
        .ex_mem_en(ex_mem_en), .ex_mem_flush(ex_mem_flush), .mem_wb_en(mem_wb_en),
        .running(running), .halted(halted),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    pipeline_hazard_ctrl #(
        .REG_ADDR_W(5), .DRAIN_CYCLES(4), .CNT_W(2)
    ) dut_sat (
        .clk(clk), .rst(rst), .enable(enable), .halt_req(halt_req),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .ex_mem_read(ex_mem_read), .ex_rt(ex_rt),
        .mem_branch(mem_branch), .mem_zero(mem_zero), .mem_jump(mem_jump),
        .dmem_wait(dmem_wait),
        .pc_en(s_pc_en), .if_id_en(s_if_id_en), .if_id_flush(s_if_id_flush),
        .id_ex_en(s_id_ex_en), .id_ex_flush(s_id_ex_flush),
        .ex_mem_en(s_ex_mem_en), .ex_mem_flush(s_ex_mem_flush), .mem_wb_en(s_mem_wb_en),
        .running(s_running), .halted(s_halted),
        .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
    );

    // Control vector order:
    // pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush,
    // ex_mem_en, ex_mem_flush, mem_wb_en, running, halted
    localparam logic [9:0] C_OFF         = 10'b0000000000;
    localparam logic [9:0] C_NORM        = 10'b1101010110;
    localparam logic [9:0] C_STALL       = 10'b0001110110;
    localparam logic [9:0] C_REDIR       = 10'b1111111110;
    localparam logic [9:0] C_FRZ_RUN     = 10'b0000000010;
    localparam logic [9:0] C_DRAIN       = 10'b0111010100;
    localparam logic [9:0] C_DRAIN_REDIR = 10'b0111111100;
    localparam logic [9:0] C_HALT        = 10'b0000000001;

    typedef struct {
        string       tag;
        logic [9:0]  ctrl;
        logic [15:0] stall;
        logic [15:0] flush;
        bit          chk_sat;
        logic [1:0]  sat_stall;
        logic [1:0]  sat_flush;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cycle_no = 0;

    logic [9:0] ctrl_obs;
    assign ctrl_obs = {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush,
                       ex_mem_en, ex_mem_flush, mem_wb_en, running, halted};

    task automatic expect_cycle(input string tag, input logic [9:0] ctrl,
                                input int st, input int fl,
                                input bit chk_sat, input int sst, input int sfl);
        exp_t e;
        e.tag       = tag;
        e.ctrl      = ctrl;
        e.stall     = 16'(st);
        e.flush     = 16'(fl);
        e.chk_sat   = chk_sat;
        e.sat_stall = 2'(sst);
        e.sat_flush = 2'(sfl);
        exp_q.push_back(e);
    endtask

    task automatic expect_main(input string tag, input logic [9:0] ctrl,
                               input int st, input int fl);
        expect_cycle(tag, ctrl, st, fl, 1'b0, 0, 0);
    endtask

    // Check on the falling edge, then advance to just after the next rising edge.
    task automatic tick();
        exp_t e;
        @(negedge clk);
        checks++;
        assert (exp_q.size() > 0) else begin
            errors++;
            $error("FAIL scoreboard_empty observed=0 entries required=1");
        end
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            $display("cycle %0d %s ctrl=%b stall=%0d flush=%0d sat=%0d/%0d",
                     cycle_no, e.tag, ctrl_obs, stall_cnt, flush_cnt,
                     s_stall_cnt, s_flush_cnt);
            checks++;
            assert (ctrl_obs === e.ctrl) else begin
                errors++;
                $error("FAIL %s ctrl observed=%b required=%b", e.tag, ctrl_obs, e.ctrl);
            end
            checks++;
            assert (stall_cnt === e.stall) else begin
                errors++;
                $error("FAIL %s stall_cnt observed=%0d required=%0d", e.tag, stall_cnt, e.stall);
            end
            checks++;
            assert (flush_cnt === e.flush) else begin
                errors++;
                $error("FAIL %s flush_cnt observed=%0d required=%0d", e.tag, flush_cnt, e.flush);
            end
            if (e.chk_sat) begin
                checks++;
                assert (s_stall_cnt === e.sat_stall) else begin
                    errors++;
                    $error("FAIL %s sat_stall_cnt observed=%0d required=%0d",
                           e.tag, s_stall_cnt, e.sat_stall);
                end
                checks++;
                assert (s_flush_cnt === e.sat_flush) else begin
                    errors++;
                    $error("FAIL %s sat_flush_cnt observed=%0d required=%0d",
                           e.tag, s_flush_cnt, e.sat_flush);
                end
            end
        end
        @(posedge clk);
        #1;
        cycle_no++;
    endtask

    task automatic clear_hazards();
        id_rs       = '0;
        id_rt       = '0;
        id_uses_rs  = 1'b0;
        id_uses_rt  = 1'b0;
        ex_mem_read = 1'b0;
        ex_rt       = '0;
        mem_branch  = 1'b0;
        mem_zero    = 1'b0;
        mem_jump    = 1'b0;
        dmem_wait   = 1'b0;
    endtask

    initial begin
        rst      = 1'b1;
        enable   = 1'b0;
        halt_req = 1'b0;
        clear_hazards();
        @(posedge clk);
        #1;

        // Reset and start-up
        expect_cycle("reset", C_OFF, 0, 0, 1'b1, 0, 0);                 tick();
        rst = 1'b0; enable = 1'b1;
        expect_main("idle_enable", C_OFF, 0, 0);                        tick();
        enable = 1'b0;  // dropping enable in RUN must not stop the CPU
        expect_main("run", C_NORM, 0, 0);                               tick();

        // Load-use on rs
        ex_mem_read = 1'b1; ex_rt = 5'd8; id_uses_rs = 1'b1; id_rs = 5'd8;
        expect_main("load_use_rs", C_STALL, 0, 0);                      tick();
        clear_hazards();
        expect_main("after_load_use", C_NORM, 1, 0);                    tick();

        // Load into $zero never stalls
        ex_mem_read = 1'b1; ex_rt = 5'd0; id_uses_rs = 1'b1; id_rs = 5'd0;
        expect_main("ex_rt_zero", C_NORM, 1, 0);                        tick();

        // Load-use on rt, then same regs but rt not read
        ex_rt = 5'd5; id_uses_rs = 1'b0; id_rs = 5'd0; id_uses_rt = 1'b1; id_rt = 5'd5;
        expect_main("load_use_rt", C_STALL, 1, 0);                      tick();
        id_uses_rt = 1'b0;
        expect_main("rt_unused", C_NORM, 2, 0);                         tick();

        // Taken branch together with load-use: redirect wins
        ex_rt = 5'd8; id_uses_rs = 1'b1; id_rs = 5'd8; mem_branch = 1'b1; mem_zero = 1'b1;
        expect_main("redirect_over_lu", C_REDIR, 2, 0);                 tick();
        clear_hazards();
        expect_main("after_redirect", C_NORM, 2, 1);                    tick();
        mem_branch = 1'b1;
        expect_main("branch_not_taken", C_NORM, 2, 1);                  tick();

        // Jump frozen by data memory for 3 cycles
        mem_branch = 1'b0; mem_jump = 1'b1; dmem_wait = 1'b1;
        for (int i = 0; i < 3; i++) begin
            expect_main("freeze", C_FRZ_RUN, 2, 1);                     tick();
        end
        dmem_wait = 1'b0;
        expect_main("jump_after_wait", C_REDIR, 2, 1);                  tick();

        // Halt with a 2-cycle freeze and a redirect mid-drain
        mem_jump = 1'b0; halt_req = 1'b1;
        expect_main("halt_req", C_NORM, 2, 2);                          tick();
        halt_req = 1'b0;
        expect_main("drain1", C_DRAIN, 2, 2);                           tick();
        dmem_wait = 1'b1;
        expect_main("drain_freeze_a", C_OFF, 2, 2);                     tick();
        expect_main("drain_freeze_b", C_OFF, 2, 2);                     tick();
        dmem_wait = 1'b0; mem_jump = 1'b1;
        expect_main("drain2_redirect", C_DRAIN_REDIR, 2, 2);            tick();
        mem_jump = 1'b0;
        expect_main("drain3", C_DRAIN, 2, 3);                           tick();
        expect_main("drain4", C_DRAIN, 2, 3);                           tick();
        enable = 1'b1;
        expect_main("halted_hold", C_HALT, 2, 3);                       tick();
        enable = 1'b0;
        expect_main("halted_exit", C_HALT, 2, 3);                       tick();
        expect_cycle("idle_counters_held", C_OFF, 2, 3, 1'b1, 2, 3);    tick();

        // Restart and saturate the 2-bit stall counter
        enable = 1'b1;
        expect_main("idle_enable2", C_OFF, 2, 3);                       tick();
        enable = 1'b0;
        ex_mem_read = 1'b1; ex_rt = 5'd8; id_uses_rs = 1'b1; id_rs = 5'd8;
        for (int i = 0; i < 5; i++) begin
            expect_main("load_use_burst", C_STALL, 2 + i, 3);           tick();
        end
        clear_hazards();
        expect_cycle("saturation", C_NORM, 7, 3, 1'b1, 3, 3);           tick();

        // Reset in the middle of a drain
        halt_req = 1'b1;
        expect_main("halt_req2", C_NORM, 7, 3);                         tick();
        halt_req = 1'b0;
        expect_main("drain_a", C_DRAIN, 7, 3);                          tick();
        rst = 1'b1;
        expect_main("drain_rst", C_DRAIN, 7, 3);                        tick();
        rst = 1'b0;
        expect_cycle("post_reset", C_OFF, 0, 0, 1'b1, 0, 0);            tick();
        expect_main("idle_stay", C_OFF, 0, 0);                          tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
